// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared CPU types and branch-predictor constants.
//   word_t          : 32-bit machine word
//   BP_ENTRIES_DEF  : default predictor table depth
//   BP_CNT_BITS_DEF : default confidence counter width
//   BP_WEAK_TAKEN   : weakly-taken init value for the default counter width
//   bp_entry_t      : one predictor entry (valid, tag, target, cnt)
//   bp_weak_taken() : weakly-taken value (MSB set, rest clear) for any width
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int BP_ENTRIES_DEF  = 16;
    localparam int BP_CNT_BITS_DEF = 2;
    localparam logic [BP_CNT_BITS_DEF-1:0] BP_WEAK_TAKEN = 2'b10;

    // Field widths cover every legal configuration: ENTRIES >= 2 leaves at
    // most 29 tag bits; counters wider than 8 bits are not supported.
    localparam int BP_TAG_MAX = 29;
    localparam int BP_CNT_MAX = 8;

    // Narrower tags/counters are zero-extended into these fields.
    typedef struct packed {
        logic                  valid;
        logic [BP_TAG_MAX-1:0] tag;
        word_t                 target;
        logic [BP_CNT_MAX-1:0] cnt;
    } bp_entry_t;

    function automatic logic [BP_CNT_MAX-1:0] bp_weak_taken(input int unsigned width);
        return BP_CNT_MAX'(1) << (width - 32'd1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- saturating up/down counter with parallel load.
//   CLK, nRST : clock, asynchronous active-low reset (count -> 0)
//   inc, dec  : step up / down, saturating at all-ones / zero
//   load      : load load_val (highest priority)
//   count     : registered counter value
module sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_r;

    // Counter register: load beats inc beats dec; both ends saturate.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_r <= CNT_MIN;
        end else if (load) begin
            count_r <= load_val;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + WIDTH'(1);
        end else if (dec && (count_r != CNT_MIN)) begin
            count_r <= count_r - WIDTH'(1);
        end
    end

    assign count = count_r;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor -- direct-mapped BTB with per-entry saturating counters.
//   CLK, nRST            : clock, asynchronous active-low reset
//   fetch_pc             : PC being fetched
//   predict_taken/target : combinational prediction for fetch_pc
//   update_*             : resolved branch report (one cycle per branch)
//   bp_clear             : synchronous invalidate of the whole table
//   branch_count         : saturating count of accepted updates
//   mispredict_count     : saturating count of updates flagged mispredict
module branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES  = BP_ENTRIES_DEF,
    parameter int CNT_BITS = BP_CNT_BITS_DEF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] fetch_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_mispredict,
    input  logic        bp_clear,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;
    localparam logic [CNT_BITS-1:0] WEAK_TAKEN = CNT_BITS'(bp_weak_taken(CNT_BITS));
    localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

    logic [IDX-1:0]      fetch_idx_s;
    logic [IDX-1:0]      upd_idx_s;
    logic [TAG_W-1:0]    fetch_tag_s;
    logic [TAG_W-1:0]    upd_tag_s;

    logic                valid_r  [ENTRIES];
    logic [TAG_W-1:0]    tag_r    [ENTRIES];
    word_t               target_r [ENTRIES];
    logic [CNT_BITS-1:0] cnt_s    [ENTRIES];

    logic [ENTRIES-1:0]  upd_sel_s;
    logic [ENTRIES-1:0]  inc_s;
    logic [ENTRIES-1:0]  dec_s;
    logic [ENTRIES-1:0]  load_s;
    logic                upd_hit_s;

    bp_entry_t           rd_entry_s;
    logic                rd_hit_s;

    logic [31:0]         branch_count_r;
    logic [31:0]         mispredict_count_r;
    logic                unused_pc_bits_s;

    assign fetch_idx_s = fetch_pc[IDX+1:2];
    assign fetch_tag_s = fetch_pc[31:IDX+2];
    assign upd_idx_s   = update_pc[IDX+1:2];
    assign upd_tag_s   = update_pc[31:IDX+2];
    assign unused_pc_bits_s = ^update_pc[1:0];

    // Lookup against pre-edge state; an update in the same cycle is not seen.
    always_comb begin
        rd_entry_s.valid  = valid_r[fetch_idx_s];
        rd_entry_s.tag    = BP_TAG_MAX'(tag_r[fetch_idx_s]);
        rd_entry_s.target = target_r[fetch_idx_s];
        rd_entry_s.cnt    = BP_CNT_MAX'(cnt_s[fetch_idx_s]);
        rd_hit_s = rd_entry_s.valid && (rd_entry_s.tag == BP_TAG_MAX'(fetch_tag_s));
        // cnt is zero-extended, so anything left after the shift is the MSB.
        predict_taken = rd_hit_s && (|(rd_entry_s.cnt >> (CNT_BITS - 1)));
        if (predict_taken) begin
            predict_target = rd_entry_s.target;
        end else begin
            predict_target = fetch_pc + 32'd4;
        end
    end

    // Update decode: one entry is selected; bp_clear suppresses all writes.
    always_comb begin
        upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
        for (int i = 0; i < ENTRIES; i++) begin
            upd_sel_s[i] = update_en && !bp_clear && (upd_idx_s == IDX'(i));
            inc_s[i]     = upd_sel_s[i] && upd_hit_s && update_taken;
            dec_s[i]     = upd_sel_s[i] && upd_hit_s && !update_taken;
            load_s[i]    = upd_sel_s[i] && !upd_hit_s && update_taken;
        end
    end

    // One confidence counter per table entry.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        sat_counter #(
            .WIDTH(CNT_BITS)
        ) u_cnt (
            .CLK     (CLK),
            .nRST    (nRST),
            .inc     (inc_s[g]),
            .dec     (dec_s[g]),
            .load    (load_s[g]),
            .load_val(WEAK_TAKEN),
            .count   (cnt_s[g])
        );
    end

    // Table storage: clear wins; allocation writes tag/target, taken hit refreshes target.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= 32'h0000_0000;
            end
        end else if (bp_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (load_s[i]) begin
                    valid_r[i]  <= 1'b1;
                    tag_r[i]    <= upd_tag_s;
                    target_r[i] <= update_target;
                end else if (inc_s[i]) begin
                    target_r[i] <= update_target;
                end
            end
        end
    end

    // Performance counters: count every update, even alongside bp_clear; saturate.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_count_r     <= 32'h0000_0000;
            mispredict_count_r <= 32'h0000_0000;
        end else if (update_en) begin
            if (branch_count_r != PERF_MAX) begin
                branch_count_r <= branch_count_r + 32'd1;
            end
            if (update_mispredict && (mispredict_count_r != PERF_MAX)) begin
                mispredict_count_r <= mispredict_count_r + 32'd1;
            end
        end
    end

    assign branch_count     = branch_count_r;
    assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor -- directed bench with an abstract table model and a
// per-cycle compare process, plus hand-computed literal checks.
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispredict;
    logic        bp_clear;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
    logic        poke_sat;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    branch_predictor dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .fetch_pc         (fetch_pc),
        .predict_taken    (predict_taken),
        .predict_target   (predict_target),
        .update_en        (update_en),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target),
        .update_mispredict(update_mispredict),
        .bp_clear         (bp_clear),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- abstract model: 16 entries, 2-bit counters ----------------
    logic        m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];
    logic [31:0] m_br;
    logic [31:0] m_mp;

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd16);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / 32'd64;
    endfunction

    function automatic logic m_taken(input logic [31:0] pc);
        int i;
        i = m_index(pc);
        return m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_cnt[i] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        if (m_taken(pc)) return m_tgt[m_index(pc)];
        return pc + 32'd4;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] <= 1'b0;
                m_cnt[i]   <= 0;
            end
            m_br <= 32'd0;
            m_mp <= 32'd0;
        end else begin
            if (update_en) begin
                if (m_br != 32'hFFFF_FFFF) m_br <= m_br + 32'd1;
                if (update_mispredict && m_mp != 32'hFFFF_FFFF) m_mp <= m_mp + 32'd1;
            end
            if (bp_clear) begin
                for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
            end else if (update_en) begin
                if (m_valid[m_index(update_pc)] && m_tag[m_index(update_pc)] == m_tagof(update_pc)) begin
                    if (update_taken) begin
                        m_cnt[m_index(update_pc)] <= (m_cnt[m_index(update_pc)] < 3) ? m_cnt[m_index(update_pc)] + 1 : 3;
                        m_tgt[m_index(update_pc)] <= update_target;
                    end else begin
                        m_cnt[m_index(update_pc)] <= (m_cnt[m_index(update_pc)] > 0) ? m_cnt[m_index(update_pc)] - 1 : 0;
                    end
                end else if (update_taken) begin
                    m_valid[m_index(update_pc)] <= 1'b1;
                    m_tag[m_index(update_pc)]   <= m_tagof(update_pc);
                    m_tgt[m_index(update_pc)]   <= update_target;
                    m_cnt[m_index(update_pc)]   <= 2;
                end
            end
            if (poke_sat) begin
                m_br <= 32'hFFFF_FFFF;
                m_mp <= 32'hFFFF_FFFF;
            end
        end
    end

    // ---------------- compare process: every cycle, away from the edge ----------------
    always @(negedge CLK) begin
        chk("cmp_taken",  {31'd0, predict_taken}, {31'd0, m_taken(fetch_pc)});
        chk("cmp_target", predict_target, m_target(fetch_pc));
        chk("cmp_brcnt",  branch_count, m_br);
        chk("cmp_mpcnt",  mispredict_count, m_mp);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic en, input logic [31:0] upc, input logic tk,
                         input logic [31:0] utg, input logic mp, input logic clr,
                         input logic [31:0] fpc);
        update_en         = en;
        update_pc         = upc;
        update_taken      = tk;
        update_target     = utg;
        update_mispredict = mp;
        bp_clear          = clr;
        fetch_pc          = fpc;
        #1;
    endtask

    task automatic idle(input logic [31:0] fpc);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, fpc);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        nRST     = 1'b0;
        poke_sat = 1'b0;
        idle(32'h0000_0040);
        repeat (3) tick();
        chk("rst_taken",  {31'd0, predict_taken}, 32'd0);
        chk("rst_target", predict_target, 32'h0000_0044);
        chk("rst_brcnt",  branch_count, 32'd0);
        chk("rst_mpcnt",  mispredict_count, 32'd0);
        nRST = 1'b1;
        tick();
        idle(32'h0000_0040);
        chk("post_rst_target", predict_target, 32'h0000_0044);

        // first allocation; same-cycle lookup must not see it
        drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 32'h40);
        chk("nobypass_taken", {31'd0, predict_taken}, 32'd0);
        tick();
        idle(32'h40);
        chk("alloc_taken",  {31'd0, predict_taken}, 32'd1);
        chk("alloc_target", predict_target, 32'h0000_0100);
        chk("alloc_brcnt",  branch_count, 32'd1);
        chk("model_pin_alloc", {31'd0, m_taken(32'h40)}, 32'd1);

        // saturate at 3, then walk down: 3 -> 2 (taken) -> 1 (not taken)
        repeat (3) begin
            drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 32'h40);
            tick();
        end
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h40);
        tick();
        idle(32'h40);
        chk("sat_nt1_taken", {31'd0, predict_taken}, 32'd1);
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h40);
        tick();
        idle(32'h40);
        chk("sat_nt2_taken",  {31'd0, predict_taken}, 32'd0);
        chk("sat_nt2_target", predict_target, 32'h0000_0044);
        chk("sat_brcnt",      branch_count, 32'd6);

        // aliasing: 0x40 and 0x80 share index 0 with tags 1 and 2
        drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 32'h40);
        tick();
        drive(1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 1'b0, 32'h40);
        tick();
        idle(32'h40);
        chk("alias_old_taken",  {31'd0, predict_taken}, 32'd0);
        chk("alias_old_target", predict_target, 32'h0000_0044);
        idle(32'h80);
        chk("alias_new_target", predict_target, 32'h0000_0300);
        chk("alias_mpcnt",      mispredict_count, 32'd1);
        chk("model_pin_alias",  m_target(32'h40), 32'h0000_0044);

        // clear alone, then same-cycle update/lookup at 0x200 on an empty table
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
        tick();
        idle(32'h80);
        chk("clear_taken", {31'd0, predict_taken}, 32'd0);
        drive(1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 1'b0, 32'h200);
        chk("same_cycle_taken",  {31'd0, predict_taken}, 32'd0);
        chk("same_cycle_target", predict_target, 32'h0000_0204);
        tick();
        idle(32'h200);
        chk("next_cycle_taken",  {31'd0, predict_taken}, 32'd1);
        chk("next_cycle_target", predict_target, 32'h0000_0400);
        idle(32'h202);
        chk("low_bits_ignored", predict_target, 32'h0000_0400);

        // not-taken miss leaves the table alone
        drive(1'b1, 32'h104, 1'b0, 32'h500, 1'b0, 1'b0, 32'h104);
        tick();
        idle(32'h104);
        chk("nt_miss_target", predict_target, 32'h0000_0108);

        // mispredict without update_en is ignored
        drive(1'b0, 32'h200, 1'b1, 32'h600, 1'b1, 1'b0, 32'h200);
        tick();
        idle(32'h200);
        chk("no_en_mpcnt",  mispredict_count, 32'd1);
        chk("no_en_brcnt",  branch_count, 32'd10);
        chk("no_en_target", predict_target, 32'h0000_0400);

        // clear beats a simultaneous update, counters still advance
        drive(1'b1, 32'h200, 1'b1, 32'h700, 1'b1, 1'b1, 32'h200);
        tick();
        idle(32'h200);
        chk("clr_upd_taken",  {31'd0, predict_taken}, 32'd0);
        chk("clr_upd_target", predict_target, 32'h0000_0204);
        chk("clr_upd_brcnt",  branch_count, 32'd11);
        chk("clr_upd_mpcnt",  mispredict_count, 32'd2);
        idle(32'hFFFF_FFFC);
        chk("wrap_target", predict_target, 32'h0000_0000);

        // perf counter saturation: preload all-ones, one more update keeps it
        idle(32'h40);
        poke_sat = 1'b1;
        @(negedge CLK);
        #1;
        force dut.branch_count_r     = 32'hFFFF_FFFF;
        force dut.mispredict_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.branch_count_r;
        release dut.mispredict_count_r;
        tick();
        poke_sat = 1'b0;
        drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 32'h40);
        tick();
        idle(32'h40);
        chk("sat_brcnt_max", branch_count, 32'hFFFF_FFFF);
        chk("sat_mpcnt_max", mispredict_count, 32'hFFFF_FFFF);
        chk("sat_alloc_taken", {31'd0, predict_taken}, 32'd1);

        // reset held across an edge aborts a pending update
        drive(1'b1, 32'h48, 1'b1, 32'h900, 1'b1, 1'b0, 32'h48);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        idle(32'h48);
        chk("rst_abort_target", predict_target, 32'h0000_004C);
        chk("rst_abort_brcnt",  branch_count, 32'd0);
        chk("rst_abort_mpcnt",  mispredict_count, 32'd0);
        idle(32'h40);
        chk("rst_abort_old", {31'd0, predict_taken}, 32'd0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
